// File: rtl/l2_set_buf_pkg.sv
// Shared types for the L2 set buffer: set/way/word widths, buffer element types and FSM states.
// L2_WAYS and WORDS_PER_LINE fall back to 8 ways x 4 words when the build does not define them.
`ifndef L2_WAYS
`define L2_WAYS 8
`endif
`ifndef WORDS_PER_LINE
`define WORDS_PER_LINE 4
`endif

package l2_set_buf_pkg;

  localparam int L2_WAYS_N = `L2_WAYS;
  localparam int WORDS_N   = `WORDS_PER_LINE;
  localparam int WORD_W    = 32;
  localparam int TAG_W     = 16;
  localparam int HPROT_W   = 1;
  localparam int STATE_W   = 3;
  localparam int SET_W     = 8;
  localparam int WAY_W     = $clog2(L2_WAYS_N);
  localparam int OFF_W     = (WORDS_N > 1) ? $clog2(WORDS_N) : 1;

  typedef logic [WORD_W-1:0]         word_t;
  typedef logic [WORDS_N*WORD_W-1:0] line_t;
  typedef logic [TAG_W-1:0]          l2_tag_t;
  typedef logic [HPROT_W-1:0]        hprot_t;
  typedef logic [STATE_W-1:0]        state_t;
  typedef logic [WAY_W-1:0]          l2_way_t;
  typedef logic [SET_W-1:0]          l2_set_t;
  typedef logic [OFF_W-1:0]          word_offset_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_WB    = 2'd2
  } l2_set_buf_state_t;

  function automatic line_t line_put(input line_t line, input word_offset_t off, input word_t data);
    line_t r;
    r = line;
    r[off*WORD_W +: WORD_W] = data;
    return r;
  endfunction

endpackage

// File: rtl/l2_set_buf_prio_enc.sv
// Lowest-set-bit encoder: picks the next dirty way to drain.
module l2_set_buf_prio_enc
  import l2_set_buf_pkg::*;
#(
  parameter int WAYS = `L2_WAYS
) (
  input  logic [WAYS-1:0] i_vec,
  output l2_way_t         o_way
);

  always_comb begin
    o_way = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (i_vec[i]) o_way = l2_way_t'(i);
    end
  end

endmodule

// File: rtl/l2_set_buf.sv
// L2 set buffer: captures one set from localmem, applies FSM word updates, drains dirty ways.
// Optional eviction-way tracking is enabled by defining L2_SET_BUF_EVICT_WAY_EN.
module l2_set_buf
  import l2_set_buf_pkg::*;
#(
  parameter int WAYS  = `L2_WAYS,
  parameter int WORDS = `WORDS_PER_LINE
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_valid,
  output logic         load_ready,
  input  l2_set_t      load_set,
  input  line_t        load_line  [WAYS],
  input  l2_tag_t      load_tag   [WAYS],
  input  hprot_t       load_hprot [WAYS],
  input  state_t       load_state [WAYS][WORDS],
  input  logic         upd_en,
  input  l2_way_t      upd_way,
  input  word_offset_t upd_word,
  input  word_t        upd_data,
  input  state_t       upd_state,
  input  logic         upd_tag_en,
  input  l2_tag_t      upd_tag,
  input  hprot_t       upd_hprot,
  input  logic         clr,
  input  logic         wb_start,
  output logic         wb_valid,
  input  logic         wb_ready,
  output l2_set_t      wb_set,
  output l2_way_t      wb_way,
  output line_t        wb_line,
  output l2_tag_t      wb_tag,
  output hprot_t       wb_hprot,
  output state_t       wb_state [WORDS],
  output logic         wb_done,
`ifdef L2_SET_BUF_EVICT_WAY_EN
  input  l2_way_t      load_evict_way,
  input  logic         evict_adv,
  output l2_way_t      evict_way,
  output logic         evict_way_wr,
`endif
  output logic         buf_valid,
  output l2_set_t      buf_set,
  output logic [WAYS-1:0] dirty,
  output line_t        lines_buf  [WAYS],
  output l2_tag_t      tags_buf   [WAYS],
  output hprot_t       hprots_buf [WAYS],
  output state_t       states_buf [WAYS][WORDS]
);

  l2_set_buf_state_t r_state, w_state_nxt;
  logic [WAYS-1:0]   r_dirty, w_dirty_nxt, w_wb_onehot;
  logic              r_wb_done, w_wb_done_nxt;
  l2_set_t           r_buf_set;
  line_t             r_lines  [WAYS];
  l2_tag_t           r_tags   [WAYS];
  hprot_t            r_hprots [WAYS];
  state_t            r_states [WAYS][WORDS];
  logic              w_clr, w_load, w_upd;
  l2_way_t           w_wb_way;

  l2_set_buf_prio_enc #(.WAYS(WAYS)) u_prio_enc (
    .i_vec (r_dirty),
    .o_way (w_wb_way)
  );

  // Event qualification in priority order: clr > load > update > wb_start.
  assign load_ready  = (r_state != ST_WB) && (r_dirty == '0);
  assign w_clr       = clr && (r_state != ST_WB);
  assign w_load      = load_valid && load_ready && !w_clr;
  assign w_upd       = upd_en && (r_state == ST_FULL) && !w_clr && !w_load;
  assign w_wb_onehot = {{(WAYS-1){1'b0}}, 1'b1} << w_wb_way;

  always_comb begin
    w_state_nxt   = r_state;
    w_dirty_nxt   = r_dirty;
    w_wb_done_nxt = 1'b0;
    if (r_state == ST_WB) begin
      if (wb_ready) begin
        w_dirty_nxt = r_dirty & ~w_wb_onehot;
        if (w_dirty_nxt == '0) begin
          w_state_nxt   = ST_FULL;
          w_wb_done_nxt = 1'b1;
        end
      end
    end else if (w_clr) begin
      w_state_nxt = ST_EMPTY;
      w_dirty_nxt = '0;
    end else if (w_load) begin
      w_state_nxt = ST_FULL;
      w_dirty_nxt = '0;
    end else if (r_state == ST_FULL) begin
      if (w_upd) w_dirty_nxt[upd_way] = 1'b1;
      // A same-cycle update counts as dirty data to drain.
      if (wb_start) begin
        if (w_dirty_nxt == '0) w_wb_done_nxt = 1'b1;
        else                   w_state_nxt   = ST_WB;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_EMPTY;
      r_dirty   <= '0;
      r_wb_done <= 1'b0;
      r_buf_set <= '0;
      for (int w = 0; w < WAYS; w++) begin
        r_lines[w]  <= '0;
        r_tags[w]   <= '0;
        r_hprots[w] <= '0;
        for (int k = 0; k < WORDS; k++) r_states[w][k] <= '0;
      end
    end else begin
      r_state   <= w_state_nxt;
      r_dirty   <= w_dirty_nxt;
      r_wb_done <= w_wb_done_nxt;
      if (w_load) begin
        r_buf_set <= load_set;
        for (int w = 0; w < WAYS; w++) begin
          r_lines[w]  <= load_line[w];
          r_tags[w]   <= load_tag[w];
          r_hprots[w] <= load_hprot[w];
          for (int k = 0; k < WORDS; k++) r_states[w][k] <= load_state[w][k];
        end
      end else if (w_upd) begin
        r_lines[upd_way]            <= line_put(r_lines[upd_way], upd_word, upd_data);
        r_states[upd_way][upd_word] <= upd_state;
        if (upd_tag_en) begin
          r_tags[upd_way]   <= upd_tag;
          r_hprots[upd_way] <= upd_hprot;
        end
      end
    end
  end

`ifdef L2_SET_BUF_EVICT_WAY_EN
  l2_way_t r_evict_way;
  logic    r_evict_wr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_evict_way <= '0;
      r_evict_wr  <= 1'b0;
    end else begin
      r_evict_wr <= 1'b0;
      if (w_load) begin
        r_evict_way <= load_evict_way;
      end else if (evict_adv && (r_state == ST_FULL) && !w_clr) begin
        // WAYS is a power of two, so natural wrap is modulo WAYS.
        r_evict_way <= r_evict_way + l2_way_t'(1);
        r_evict_wr  <= 1'b1;
      end
    end
  end

  assign evict_way    = r_evict_way;
  assign evict_way_wr = r_evict_wr;
`endif

  assign buf_valid = (r_state != ST_EMPTY);
  assign buf_set   = r_buf_set;
  assign dirty     = r_dirty;
  assign wb_done   = r_wb_done;
  assign wb_valid  = (r_state == ST_WB);
  assign wb_set    = r_buf_set;
  assign wb_way    = w_wb_way;
  assign wb_line   = r_lines[w_wb_way];
  assign wb_tag    = r_tags[w_wb_way];
  assign wb_hprot  = r_hprots[w_wb_way];

  for (genvar k = 0; k < WORDS; k++) begin : g_wb_state
    assign wb_state[k] = r_states[w_wb_way][k];
  end

  for (genvar w = 0; w < WAYS; w++) begin : g_buf_out
    assign lines_buf[w]  = r_lines[w];
    assign tags_buf[w]   = r_tags[w];
    assign hprots_buf[w] = r_hprots[w];
    for (genvar k = 0; k < WORDS; k++) begin : g_word
      assign states_buf[w][k] = r_states[w][k];
    end
  end

endmodule

// File: tb/tb_l2_set_buf.sv
// Directed bench for l2_set_buf: a set-level reference model checked every cycle plus literal expectations.
module tb_l2_set_buf;
  import l2_set_buf_pkg::*;

  localparam int WAYS  = L2_WAYS_N;
  localparam int WORDS = WORDS_N;

  logic         clk, rst;
  logic         load_valid, load_ready;
  l2_set_t      load_set;
  line_t        load_line  [WAYS];
  l2_tag_t      load_tag   [WAYS];
  hprot_t       load_hprot [WAYS];
  state_t       load_state [WAYS][WORDS];
  logic         upd_en, upd_tag_en, clr, wb_start, wb_valid, wb_ready, wb_done, buf_valid;
  l2_way_t      upd_way, wb_way;
  word_offset_t upd_word;
  word_t        upd_data;
  state_t       upd_state;
  l2_tag_t      upd_tag, wb_tag;
  hprot_t       upd_hprot, wb_hprot;
  l2_set_t      wb_set, buf_set;
  line_t        wb_line;
  state_t       wb_state [WORDS];
  logic [WAYS-1:0] dirty;
  line_t        lines_buf  [WAYS];
  l2_tag_t      tags_buf   [WAYS];
  hprot_t       hprots_buf [WAYS];
  state_t       states_buf [WAYS][WORDS];

  l2_set_buf #(.WAYS(WAYS), .WORDS(WORDS)) dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_ready(load_ready), .load_set(load_set),
    .load_line(load_line), .load_tag(load_tag), .load_hprot(load_hprot), .load_state(load_state),
    .upd_en(upd_en), .upd_way(upd_way), .upd_word(upd_word), .upd_data(upd_data),
    .upd_state(upd_state), .upd_tag_en(upd_tag_en), .upd_tag(upd_tag), .upd_hprot(upd_hprot),
    .clr(clr), .wb_start(wb_start), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_set(wb_set), .wb_way(wb_way), .wb_line(wb_line), .wb_tag(wb_tag),
    .wb_hprot(wb_hprot), .wb_state(wb_state), .wb_done(wb_done),
    .buf_valid(buf_valid), .buf_set(buf_set), .dirty(dirty),
    .lines_buf(lines_buf), .tags_buf(tags_buf), .hprots_buf(hprots_buf), .states_buf(states_buf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int beats[$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: the set as seen by the controller, plus "draining" flag.
  bit              m_init, m_valid, m_wb, m_done;
  logic [WAYS-1:0] m_dirty;
  l2_set_t         m_set;
  line_t           m_lines [WAYS];
  l2_tag_t         m_tags  [WAYS];
  hprot_t          m_hp    [WAYS];
  state_t          m_st    [WAYS][WORDS];

  function automatic int lowest(input logic [WAYS-1:0] v);
    for (int i = 0; i < WAYS; i++) if (v[i]) return i;
    return 0;
  endfunction

  always @(posedge clk) begin : model
    bit lr, done_n;
    int w;
    if (rst) begin
      m_init = 1; m_valid = 0; m_wb = 0; m_done = 0; m_dirty = '0; m_set = '0;
      for (int i = 0; i < WAYS; i++) begin
        m_lines[i] = '0; m_tags[i] = '0; m_hp[i] = '0;
        for (int k = 0; k < WORDS; k++) m_st[i][k] = '0;
      end
    end else begin
      lr = !m_wb && (m_dirty == '0);
      done_n = 0;
      if (m_wb) begin
        if (wb_ready) begin
          w = lowest(m_dirty);
          m_dirty[w] = 1'b0;
          if (m_dirty == '0) begin m_wb = 0; done_n = 1; end
        end
      end else if (clr) begin
        m_valid = 0; m_dirty = '0;
      end else if (load_valid && lr) begin
        m_valid = 1; m_dirty = '0; m_set = load_set;
        for (int i = 0; i < WAYS; i++) begin
          m_lines[i] = load_line[i]; m_tags[i] = load_tag[i]; m_hp[i] = load_hprot[i];
          for (int k = 0; k < WORDS; k++) m_st[i][k] = load_state[i][k];
        end
      end else if (m_valid) begin
        if (upd_en) begin
          m_lines[upd_way][int'(upd_word)*32 +: 32] = upd_data;
          m_st[upd_way][upd_word] = upd_state;
          if (upd_tag_en) begin m_tags[upd_way] = upd_tag; m_hp[upd_way] = upd_hprot; end
          m_dirty[upd_way] = 1'b1;
        end
        if (wb_start) begin
          if (m_dirty == '0) done_n = 1;
          else m_wb = 1;
        end
      end
      m_done = done_n;
    end
  end

  always @(posedge clk) begin
    if (!rst && wb_valid && wb_ready) beats.push_back(int'(wb_way));
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("load_ready", load_ready, !m_wb && (m_dirty == '0));
      chk("buf_valid", buf_valid, m_valid);
      chk("buf_set", buf_set, m_set);
      chk("dirty", dirty, m_dirty);
      chk("wb_valid", wb_valid, m_wb);
      chk("wb_done", wb_done, m_done);
      for (int w = 0; w < WAYS; w++) begin
        chk($sformatf("lines_buf[%0d]", w), lines_buf[w], m_lines[w]);
        chk($sformatf("tags_buf[%0d]", w), tags_buf[w], m_tags[w]);
        chk($sformatf("hprots_buf[%0d]", w), hprots_buf[w], m_hp[w]);
        for (int k = 0; k < WORDS; k++)
          chk($sformatf("states_buf[%0d][%0d]", w, k), states_buf[w][k], m_st[w][k]);
      end
      if (m_wb) begin
        chk("wb_way", wb_way, lowest(m_dirty));
        chk("wb_set", wb_set, m_set);
        chk("wb_line", wb_line, m_lines[lowest(m_dirty)]);
        chk("wb_tag", wb_tag, m_tags[lowest(m_dirty)]);
        chk("wb_hprot", wb_hprot, m_hp[lowest(m_dirty)]);
        for (int k = 0; k < WORDS; k++)
          chk($sformatf("wb_state[%0d]", k), wb_state[k], m_st[lowest(m_dirty)][k]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_load(input logic [7:0] s, input int tag_base);
    load_set = s;
    for (int w = 0; w < WAYS; w++) begin
      load_tag[w]   = l2_tag_t'(tag_base + w);
      load_hprot[w] = hprot_t'(w & 1);
      load_line[w]  = {WORDS{32'hA000_0000 | 32'(w)}};
      for (int k = 0; k < WORDS; k++) load_state[w][k] = state_t'((w + k) % 5);
    end
  endtask

  task automatic set_upd(input int w, input int k, input logic [31:0] d, input bit te, input logic [15:0] t);
    upd_en = 1'b1; upd_way = l2_way_t'(w); upd_word = word_offset_t'(k);
    upd_data = d; upd_state = state_t'(3'd6); upd_tag_en = te; upd_tag = t; upd_hprot = 1'b1;
  endtask

  initial begin
    rst = 1; load_valid = 0; upd_en = 0; upd_tag_en = 0; clr = 0; wb_start = 0; wb_ready = 0;
    upd_way = '0; upd_word = '0; upd_data = '0; upd_state = '0; upd_tag = '0; upd_hprot = '0;
    set_load(8'h00, 0);
    repeat (3) step();
    chk("rst buf_valid", buf_valid, 0);
    chk("rst dirty", dirty, 0);
    chk("rst wb_valid", wb_valid, 0);
    chk("rst wb_done", wb_done, 0);
    chk("rst load_ready", load_ready, 1);
    rst = 0;

    // Load set 0x12, tags 0x100+way
    set_load(8'h12, 'h100); load_valid = 1;
    step(); load_valid = 0;
    chk("ld buf_valid", buf_valid, 1);
    chk("ld buf_set", buf_set, 8'h12);
    chk("ld tags_buf3", tags_buf[3], 16'h103);
    chk("ld dirty", dirty, 0);

    // Single dirty word, drained in one beat
    set_upd(2, 1, 32'hDEAD, 0, 0);
    step(); upd_en = 0;
    chk("upd dirty", dirty, 8'b0000_0100);
    beats.delete();
    wb_start = 1; step(); wb_start = 0;
    chk("wb1 valid", wb_valid, 1);
    chk("wb1 way", wb_way, 2);
    chk("wb1 word1", wb_line[63:32], 32'hDEAD);
    chk("wb1 word0", wb_line[31:0], 32'hA000_0002);
    wb_ready = 1; step(); wb_ready = 0;
    chk("wb1 done", wb_done, 1);
    chk("wb1 dirty", dirty, 0);
    chk("wb1 beats", beats.size(), 1);
    step();
    chk("wb1 done pulse", wb_done, 0);

    // wb_start with nothing dirty
    beats.delete();
    wb_start = 1; step(); wb_start = 0;
    chk("wb0 done", wb_done, 1);
    chk("wb0 valid", wb_valid, 0);
    step();
    chk("wb0 done pulse", wb_done, 0);
    chk("wb0 beats", beats.size(), 0);

    // Dirty ways 1, 5, 6 with wb_ready toggling
    set_upd(1, 0, 32'h1111, 0, 0); step();
    set_upd(5, 2, 32'h5555, 0, 0); step();
    set_upd(6, 3, 32'h6666, 1, 16'h3C6); step();
    upd_en = 0; upd_tag_en = 0;
    chk("multi dirty", dirty, 8'b0110_0010);
    beats.delete();
    wb_start = 1; step(); wb_start = 0;
    chk("multi way a", wb_way, 1);
    chk("multi lr a", load_ready, 0);
    wb_ready = 1; step();
    chk("multi way b", wb_way, 5);
    wb_ready = 0; step();
    chk("multi hold way", wb_way, 5);
    chk("multi hold data", wb_line[95:64], 32'h5555);
    chk("multi lr b", load_ready, 0);
    wb_ready = 1; step();
    chk("multi way c", wb_way, 6);
    chk("multi tag c", wb_tag, 16'h3C6);
    wb_ready = 0; step();
    chk("multi hold c", wb_way, 6);
    wb_ready = 1; step(); wb_ready = 0;
    chk("multi done", wb_done, 1);
    chk("multi lr done", load_ready, 1);
    chk("multi nbeats", beats.size(), 3);
    if (beats.size() == 3) begin
      chk("multi beat0", beats[0], 1);
      chk("multi beat1", beats[1], 5);
      chk("multi beat2", beats[2], 6);
    end

    // Load and update together: load wins
    set_load(8'h34, 'h200); load_valid = 1;
    set_upd(0, 0, 32'hBEEF, 0, 0);
    step(); load_valid = 0; upd_en = 0;
    chk("ldupd dirty", dirty, 0);
    chk("ldupd set", buf_set, 8'h34);
    chk("ldupd tag0", tags_buf[0], 16'h200);
    chk("ldupd word0", lines_buf[0][31:0], 32'hA000_0000);

    // clr invalidates but keeps contents
    clr = 1; step(); clr = 0;
    chk("clr valid", buf_valid, 0);
    chk("clr tag1", tags_buf[1], 16'h201);

    // Reset during the second writeback beat
    set_load(8'h56, 'h300); load_valid = 1; step(); load_valid = 0;
    set_upd(0, 2, 32'h0A0A, 0, 0); step();
    set_upd(3, 1, 32'h0B0B, 0, 0); step();
    upd_en = 0;
    beats.delete();
    wb_start = 1; step(); wb_start = 0;
    wb_ready = 1; step();
    chk("abort way", wb_way, 3);
    rst = 1; step(); rst = 0; wb_ready = 0;
    chk("abort buf_valid", buf_valid, 0);
    chk("abort buf_set", buf_set, 0);
    chk("abort dirty", dirty, 0);
    chk("abort wb_valid", wb_valid, 0);
    chk("abort wb_done", wb_done, 0);
    chk("abort tags3", tags_buf[3], 0);
    step();
    chk("abort no done a", wb_done, 0);
    step();
    chk("abort no done b", wb_done, 0);
    chk("abort beats", beats.size(), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
